// File: rtl/mul_rr_scheduler.sv
// Round-robin front end that time-shares one combinational signed 16x16 multiplier
// among NREQ requesters, with one operation in flight and a held response.
`timescale 1ns/1ps

module mul_booth16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  logic [31:0] pp [8];
  logic [16:0] bx;
  logic [31:0] a_ext;
  logic [31:0] a_dbl;

  assign bx    = {b, 1'b0};
  assign a_ext = {{16{a[15]}}, a};
  assign a_dbl = a_ext << 1;

  // Radix-4 Booth recoding: each digit in {-2..2} selects one shifted partial product.
  always_comb begin
    logic [31:0] row;
    for (int j = 0; j < 8; j++) begin
      row = '0;
      case (bx[2*j +: 3])
        3'b001, 3'b010: row = a_ext;
        3'b011:         row = a_dbl;
        3'b100:         row = -a_dbl;
        3'b101, 3'b110: row = -a_ext;
        default:        row = '0;
      endcase
      pp[j] = row << (2*j);
    end
  end

  function automatic logic [63:0] csa(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    logic [31:0] s;
    logic [31:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  logic [31:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  // Wallace reduction 8 -> 6 -> 4 -> 3 -> 2 rows, then one carry-propagate add.
  assign {c0, s0} = csa(pp[0], pp[1], pp[2]);
  assign {c1, s1} = csa(pp[3], pp[4], pp[5]);
  assign {c2, s2} = csa(s0, c0, s1);
  assign {c3, s3} = csa(c1, pp[6], pp[7]);
  assign {c4, s4} = csa(s2, c2, s3);
  assign {c5, s5} = csa(s4, c4, c3);
  assign p = s5 + c5;
endmodule

module mul_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_data,
  input  logic                 resp_ready,
  output logic                 busy,
  output logic [1:0]           state_dbg
);
  // Handshakes: a request transfers on the edge where req_valid[i] & req_ready[i];
  // a response transfers on the edge where resp_valid & resp_ready. Neither side
  // may make its valid depend on the other side's ready.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  id_reg;
  logic [2:0]      cnt;
  logic [15:0]     op_a;
  logic [15:0]     op_b;
  logic [31:0]     mul_p;

  logic            grant_hit;
  logic [IDW-1:0]  grant_idx;
  logic [IDW:0]    idx_w;
  logic [NREQ-1:0] grant_vec;
  logic [15:0]     sel_a;
  logic [15:0]     sel_b;

  mul_booth16 u_mul (.a(op_a), .b(op_b), .p(mul_p));

  // First pending request at or after rr_ptr, searching upward with wrap.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    idx_w     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_w = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx_w >= (IDW+1)'(NREQ)) idx_w = idx_w - (IDW+1)'(NREQ);
      if (!grant_hit && req_valid[idx_w[IDW-1:0]]) begin
        grant_hit = 1'b1;
        grant_idx = idx_w[IDW-1:0];
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (state == IDLE && !rst && grant_hit) grant_vec[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vec[i]) begin
        sel_a = req_a[16*i +: 16];
        sel_b = req_b[16*i +: 16];
      end
    end
  end

  assign req_ready = grant_vec;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_reg     <= '0;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_hit) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            id_reg <= grant_idx;
            cnt    <= '0;
            rr_ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
            state  <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt + 3'd1;
          // Operands have been stable for LAT cycles; the product has settled.
          if (cnt == 3'(LAT-1)) begin
            resp_data  <= mul_p;
            resp_id    <= id_reg;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
